// File: rtl/bit_manip_dispatch.sv
// Request FIFO, single-issue sequencer and result holding stage around the
// int_bit_manip datapath: requests in order, one in flight, results in order.
module bit_manip_dispatch #(
  parameter int DEPTH   = 4,
  parameter int LATENCY = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [2:0]               req_op,
  input  logic [63:0]              req_opa,
  input  logic [63:0]              req_opb,
  output logic [2:0]               bm_operation,
  output logic [63:0]              bm_opa,
  output logic [63:0]              bm_opb,
  input  logic [63:0]              bm_result,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [63:0]              res_data,
  output logic [2:0]               res_op,
  output logic                     res_err,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  typedef struct packed {
    logic [2:0]  op;
    logic [63:0] opa;
    logic [63:0] opb;
  } req_t;

  req_t          mem_q [DEPTH];
  req_t          head;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [1:0]    state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [2:0]    bm_op_q, bm_op_d;
  logic [63:0]   bm_opa_q, bm_opa_d;
  logic [63:0]   bm_opb_q, bm_opb_d;
  logic [63:0]   res_data_q, res_data_d;
  logic [2:0]    res_op_q, res_op_d;
  logic          res_err_q, res_err_d;
  logic          push, pop;

  // Ready comes from registered occupancy, so a pop at full only reopens
  // the input one cycle later.
  assign req_ready = (count_q < CW'(DEPTH));
  assign push      = req_valid && req_ready;
  assign pop       = (state_q == S_IDLE) && (count_q != '0);
  assign head      = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= '{op: req_op, opa: req_opa, opb: req_opb};
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (!push && pop) count_d = count_q - CW'(1);
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bm_op_d    = bm_op_q;
    bm_opa_d   = bm_opa_q;
    bm_opb_d   = bm_opb_q;
    res_data_d = res_data_q;
    res_op_d   = res_op_q;
    res_err_d  = res_err_q;
    case (state_q)
      S_IDLE: begin
        if (pop) begin
          if (!head.op[2]) begin
            bm_op_d  = head.op;
            bm_opa_d = head.opa;
            bm_opb_d = head.opb;
            cnt_d    = 4'(LATENCY);
            state_d  = S_WAIT;
          end else begin
            // Illegal ops bypass the datapath entirely.
            res_data_d = '0;
            res_op_d   = head.op;
            res_err_d  = 1'b1;
            state_d    = S_HOLD;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          res_data_d = bm_result;
          res_op_d   = bm_op_q;
          res_err_d  = 1'b0;
          state_d    = S_HOLD;
        end
      end
      S_HOLD: begin
        if (res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bm_op_q    <= 3'd3;
      bm_opa_q   <= '0;
      bm_opb_q   <= '0;
      res_data_q <= '0;
      res_op_q   <= '0;
      res_err_q  <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bm_op_q    <= bm_op_d;
      bm_opa_q   <= bm_opa_d;
      bm_opb_q   <= bm_opb_d;
      res_data_q <= res_data_d;
      res_op_q   <= res_op_d;
      res_err_q  <= res_err_d;
    end
  end

  assign bm_operation = bm_op_q;
  assign bm_opa       = bm_opa_q;
  assign bm_opb       = bm_opb_q;
  assign res_valid    = (state_q == S_HOLD);
  assign res_data     = res_data_q;
  assign res_op       = res_op_q;
  assign res_err      = res_err_q;
  assign count        = count_q;
  assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_bit_manip_dispatch.sv
// Directed bench for bit_manip_dispatch with a behavioural int_bit_manip
// model closing the datapath loop.
module tb_bit_manip_dispatch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = '0;
  logic [63:0] req_opa = '0;
  logic [63:0] req_opb = '0;
  logic [2:0]  bm_operation;
  logic [63:0] bm_opa, bm_opb, bm_result, bit_m;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [63:0] res_data;
  logic [2:0]  res_op;
  logic        res_err;
  logic [2:0]  count;
  logic        busy;

  int checks = 0;
  int failures = 0;
  int op5_seen = 0;

  bit_manip_dispatch #(.DEPTH(4), .LATENCY(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_opa(req_opa), .req_opb(req_opb),
    .bm_operation(bm_operation), .bm_opa(bm_opa), .bm_opb(bm_opb),
    .bm_result(bm_result),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_op(res_op), .res_err(res_err),
    .count(count), .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural int_bit_manip: combinational, index from opb[5:0].
  assign bit_m = 64'd1 << bm_opb[5:0];
  always_comb begin
    bm_result = '0;
    case (bm_operation)
      3'd0:    bm_result = bm_opa & ~bit_m;
      3'd1:    bm_result = bm_opa | bit_m;
      3'd2:    bm_result = bm_opa & bit_m;
      3'd3:    bm_result = bm_opa;
      default: bm_result = '0;
    endcase
  end

  always @(negedge clk) if (bm_operation == 3'd5) op5_seen <= op5_seen + 1;

  typedef struct {
    logic [2:0]  op;
    logic [63:0] opa;
    logic [63:0] opb;
    logic [63:0] data;
    logic [2:0]  rop;
    logic        err;
    int          lat;
    logic [2:0]  bmop;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic bound_fail(input string nm);
    checks++;
    failures++;
    $display("FAIL %s timed out", nm);
  endtask

  task automatic push_req(input logic [2:0] op, input logic [63:0] opa, input logic [63:0] opb);
    bit ok;
    ok = 0;
    req_valid = 1'b1; req_op = op; req_opa = opa; req_opb = opb;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (req_ready) begin
        @(posedge clk); #1;
        ok = 1;
        break;
      end
    end
    req_valid = 1'b0;
    if (!ok) bound_fail("push_req");
  endtask

  task automatic wait_res(output int lat, output bit got);
    lat = 0; got = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (res_valid) begin got = 1; break; end
      @(posedge clk);
      lat++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, nres, acc, base5, seen;
    bit got, sixth, full_idle, chk_next, accept;
    logic [63:0] rd [8];
    logic [2:0]  ro [8];
    logic        re [8];

    tbl[0] = '{3'd0, 64'hFFFF, 64'd15, 64'h7FFF, 3'd0, 1'b0, 3, 3'd0};
    tbl[1] = '{3'd1, 64'h0,    64'd15, 64'h8000, 3'd1, 1'b0, 3, 3'd1};
    tbl[2] = '{3'd2, 64'hFFFF, 64'd8,  64'h0100, 3'd2, 1'b0, 3, 3'd2};
    tbl[3] = '{3'd3, 64'hFFFF, 64'd11, 64'hFFFF, 3'd3, 1'b0, 3, 3'd3};
    tbl[4] = '{3'd2, 64'hFF00, 64'd3,  64'h0,    3'd2, 1'b0, 3, 3'd2};
    tbl[5] = '{3'd1, 64'h0,    64'd63, 64'h8000_0000_0000_0000, 3'd1, 1'b0, 3, 3'd1};
    tbl[6] = '{3'd0, 64'hFFFF, 64'd79, 64'h7FFF, 3'd0, 1'b0, 3, 3'd0};
    tbl[7] = '{3'd6, 64'h1234, 64'd2,  64'h0,    3'd6, 1'b1, 1, 3'd0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_bm_op", 64'(bm_operation), 64'd3);
    chk("rst_bm_opa", bm_opa, 64'd0);
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Table vectors, downstream always ready
    res_ready = 1'b1;
    for (int v = 0; v < 8; v++) begin
      push_req(tbl[v].op, tbl[v].opa, tbl[v].opb);
      wait_res(lat, got);
      if (!got) bound_fail($sformatf("vec%0d_result", v));
      else begin
        chk($sformatf("vec%0d_latency", v), 64'(lat), 64'(tbl[v].lat));
        chk($sformatf("vec%0d_data", v), res_data, tbl[v].data);
        chk($sformatf("vec%0d_op", v), 64'(res_op), 64'(tbl[v].rop));
        chk($sformatf("vec%0d_err", v), 64'(res_err), 64'(tbl[v].err));
        chk($sformatf("vec%0d_bmop", v), 64'(bm_operation), 64'(tbl[v].bmop));
        if (!tbl[v].err) chk($sformatf("vec%0d_bmopb", v), bm_opb, tbl[v].opb);
      end
      @(posedge clk); #1;
    end

    // Overflow with downstream stalled
    res_ready = 1'b0;
    acc = 0;
    for (int k = 0; k < 6; k++) begin
      req_valid = 1'b1; req_op = 3'd1; req_opa = '0; req_opb = 64'(k);
      @(negedge clk);
      if (!req_ready) begin
        chk("ovf_full_count", 64'(count), 64'd4);
        break;
      end
      @(posedge clk); #1;
      acc++;
    end
    chk("ovf_accepted", 64'(acc), 64'd5);
    repeat (4) @(negedge clk);
    chk("ovf_stall_valid", 64'(res_valid), 64'd1);
    chk("ovf_stall_data", res_data, 64'h1);
    chk("ovf_stall_ready", 64'(req_ready), 64'd0);
    @(posedge clk); #1;
    res_ready = 1'b1;
    nres = 0; sixth = 0; full_idle = 0; chk_next = 0;
    for (int c = 0; c < 100 && nres < 6; c++) begin
      @(negedge clk);
      if (chk_next) begin
        chk("simul_count", 64'(count), 64'd3);
        chk("simul_ready_next", 64'(req_ready), 64'd1);
        chk_next = 0;
      end
      if (!busy && count == 3'd4 && req_valid) begin
        chk("simul_ready_full", 64'(req_ready), 64'd0);
        full_idle = 1; chk_next = 1;
      end
      if (res_valid) begin rd[nres] = res_data; nres++; end
      accept = req_valid && req_ready;
      @(posedge clk); #1;
      if (accept) begin req_valid = 1'b0; sixth = 1; end
    end
    req_valid = 1'b0;
    chk("simul_seen", 64'(full_idle), 64'd1);
    chk("ovf_sixth_accepted", 64'(sixth), 64'd1);
    chk("ovf_nres", 64'(nres), 64'd6);
    for (int i = 0; i < nres; i++)
      chk($sformatf("ovf_res%0d", i), rd[i], 64'd1 << i);

    // Illegal op between two legal ones
    base5 = op5_seen;
    res_ready = 1'b0;
    push_req(3'd3, 64'hDEAD_BEEF_0000_1111, 64'd7);
    push_req(3'd5, 64'hFFFF, 64'd1);
    push_req(3'd3, 64'h0123_4567_89AB_CDEF, 64'd2);
    @(posedge clk); #1;
    res_ready = 1'b1;
    nres = 0;
    for (int c = 0; c < 60 && nres < 3; c++) begin
      @(negedge clk);
      if (res_valid) begin
        rd[nres] = res_data; ro[nres] = res_op; re[nres] = res_err; nres++;
      end
      @(posedge clk); #1;
    end
    if (nres != 3) bound_fail("ill_results");
    else begin
      chk("ill_r0_data", rd[0], 64'hDEAD_BEEF_0000_1111);
      chk("ill_r0_err", 64'(re[0]), 64'd0);
      chk("ill_r1_data", rd[1], 64'h0);
      chk("ill_r1_op", 64'(ro[1]), 64'd5);
      chk("ill_r1_err", 64'(re[1]), 64'd1);
      chk("ill_r2_data", rd[2], 64'h0123_4567_89AB_CDEF);
      chk("ill_r2_op", 64'(ro[2]), 64'd3);
      chk("ill_r2_err", 64'(re[2]), 64'd0);
    end
    chk("ill_bm_op5_never", 64'(op5_seen - base5), 64'd0);

    // Reset asserted mid-WAIT with a second request queued
    push_req(3'd1, 64'h0, 64'd9);
    push_req(3'd1, 64'h0, 64'd10);
    chk("mid_busy", 64'(busy), 64'd1);
    chk("mid_count", 64'(count), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_count", 64'(count), 64'd0);
    chk("mid_rst_ready", 64'(req_ready), 64'd1);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_bm_op", 64'(bm_operation), 64'd3);
    chk("mid_rst_bm_opa", bm_opa, 64'd0);
    chk("mid_rst_bm_opb", bm_opb, 64'd0);
    chk("mid_rst_res_valid", 64'(res_valid), 64'd0);
    chk("mid_rst_res_data", res_data, 64'd0);
    chk("mid_rst_res_op", 64'(res_op), 64'd0);
    chk("mid_rst_res_err", 64'(res_err), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (res_valid || busy) seen++;
    end
    chk("post_rst_no_result", 64'(seen), 64'd0);
    chk("post_rst_count", 64'(count), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bit_manip_dispatch.md
# bit_manip_dispatch

Request buffer and result capture stage wrapped around the `int_bit_manip` datapath. It accepts bit-manipulation requests (operation, opa, opb) over a valid/ready handshake and queues them in a small FIFO. It issues one request at a time to `int_bit_manip` through registered operand outputs, waits a fixed latency, then captures `out_bit` and presents it downstream over a second valid/ready handshake.

## Interface
- `DEPTH`, 4: request FIFO entries; power of two, 2..16.
- `LATENCY`, 2: clock edges from the operand-register update to the edge that captures `bm_result`; range 1..15.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: FIFO can accept; equals `count < DEPTH`.
- `req_op` in 3: 0 clear bit, 1 set bit, 2 get bit, 3 pass opa, 4-7 illegal.
- `req_opa` in 64: operand A.
- `req_opb` in 64: bit index; only `[5:0]` is meaningful to the datapath.
- `bm_operation` out 3: registered drive to `int_bit_manip.operation`.
- `bm_opa` out 64: registered drive to `opa_bit`.
- `bm_opb` out 64: registered drive to `opb_bit`.
- `bm_result` in 64: from `int_bit_manip.out_bit`.
- `res_valid` out 1: result present.
- `res_ready` in 1: downstream accepts.
- `res_data` out 64: captured result.
- `res_op` out 3: operation that produced `res_data`.
- `res_err` out 1: result came from an illegal op.
- `count` out $clog2(DEPTH)+1: FIFO occupancy.
- `busy` out 1: state is not IDLE.

## Operation
- **FIFO push:** occurs when `req_valid && req_ready` at a rising edge.
- **FIFO pop:** only the FSM pops, in IDLE.
- **Simultaneous push and pop:** both take effect and `count` is unchanged.
- **Full FIFO:** `req_ready` is 0 and the request is held off. The pop in that cycle does not re-open `req_ready` until the next cycle, because `req_ready` is derived from the registered `count`.
- **IDLE:**
  - FIFO empty: stay in IDLE.
  - Head op is 0-3: pop, load the `bm_*` registers from the head entry, load `cnt` = LATENCY, go to WAIT.
  - Head op is 4-7: pop, leave the `bm_*` registers unchanged, load `res_data`=0, `res_op`=op, `res_err`=1, go to HOLD. The illegal op is never driven to the datapath.
- **WAIT:** decrement `cnt` each edge. On the edge where `cnt`==1, capture `res_data`=`bm_result`, `res_op`=`bm_operation`, `res_err`=0, and go to HOLD.
- **HOLD:**
  - `res_valid`=1.
  - `res_data`, `res_op` and `res_err` are stable until the handshake completes.
  - On `res_valid && res_ready`, go to IDLE.
- **In flight:** at most one request is in flight. Results leave in request order.
- **Operand width:** operands pass through unmodified at 64 bits; no masking of opb occurs in this block.

## Timing
- **Reset values (while `rst_n`=0, asynchronous):**
  - State IDLE, `count`=0, `req_ready`=1.
  - `bm_operation`=3, `bm_opa`=0, `bm_opb`=0.
  - `res_valid`=0, `res_data`=0, `res_op`=0, `res_err`=0, `busy`=0.
  - FIFO pointers 0.
- **Reset mid-operation:** queued and in-flight requests are discarded and no result is emitted.
- **Legal-op latency:** request accepted at edge E0 → popped and `bm_*` updated at E1 → result captured at E1+LATENCY → `res_valid` high from then. That is LATENCY+1 edges after E0; 3 with the default.
- **Illegal-op latency:** accepted at E0 → `res_valid` high after E1.
- **Throughput with `res_ready` tied high:**
  - Legal op: one result per LATENCY+2 cycles (IDLE, WAIT×LATENCY, HOLD).
  - Illegal op: one result per 2 cycles.
- **Downstream stall:** `res_ready`=0 holds HOLD indefinitely. The FIFO keeps accepting requests until full.
- **`bm_*` hold:** the `bm_*` outputs keep their last issued values between requests.

## Test plan
- **Reset check:** assert `rst_n`=0 mid-WAIT → all outputs at reset values immediately. After release, `req_ready`=1 and `count`=0.
- **Single legal ops, `res_ready`=1:** res_valid rises 3 edges after acceptance (LATENCY=2), `res_err`=0.
  - op0, opa=0xFFFF, opb=15 → `res_data`=0x7FFF.
  - op1, opa=0, opb=15 → `res_data`=0x8000.
  - op2, opa=0xFFFF, opb=8 → `res_data`=0x0100.
  - op3, opa=0xFFFF, opb=11 → `res_data`=0xFFFF.
- **Overflow:** hold `res_ready`=0 and push 6 back-to-back requests (op1, opa=0, opb=0..5).
  - `req_ready` drops when `count`=4. Only the first 5 are accepted: 4 queued plus 1 in HOLD.
  - Release `res_ready` → results 0x1, 0x2, 0x4, 0x8, 0x10 in order.
  - The 6th request is accepted once space frees, giving 0x20.
- **Illegal op:** push op5 between two op3 requests → middle result has `res_err`=1, `res_data`=0, `res_op`=5.
  - `bm_operation` never shows 5.
  - Neighbouring results are correct.
- **Simultaneous push/pop at full:** with `count`=4 in IDLE, drive `req_valid`=1 → the pop occurs, `count` becomes 3, and `req_ready` stays 0 that cycle. The push is accepted on the next cycle.
